// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of one block-RAM port, with a bounded
// lock extension, a registered RAM interface and a fixed 2-cycle response pipeline.
module ram_port_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 9,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rsp_valid,
  output logic [DATA_W-1:0] r0_rsp_data,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] r1_rsp_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  logic       last_owner_r;
  logic [7:0] streak_r;
  logic       last_owner_nxt_s;
  logic [7:0] streak_nxt_s;
  logic       contended_s;
  logic       any_s;
  logic       keep_s;
  logic       grant1_s;
  logic       s1_valid_r;
  logic       s1_tag_r;
  logic       r0_rsp_valid_r;
  logic       r1_rsp_valid_r;

  // Grant decision: the current owner keeps a contended grant only while locked and under the hold bound.
  always_comb begin
    contended_s = r0_valid & r1_valid;
    any_s       = r0_valid | r1_valid;
    keep_s      = (last_owner_r ? r1_lock : r0_lock) & (streak_r < MAX_HOLD_C);
    grant1_s    = 1'b0;
    if (contended_s) begin
      if (keep_s) begin
        grant1_s = last_owner_r;
      end else begin
        grant1_s = ~last_owner_r;
      end
    end else if (r1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant1_s = 1'b0;
    end
  end

  assign r0_ready = any_s & ~grant1_s;
  assign r1_ready = any_s & grant1_s;

  // Ownership and contended-streak bookkeeping for the next cycle.
  always_comb begin
    last_owner_nxt_s = last_owner_r;
    streak_nxt_s     = streak_r;
    if (any_s) begin
      if (grant1_s != last_owner_r) begin
        last_owner_nxt_s = grant1_s;
        streak_nxt_s     = contended_s ? 8'd1 : 8'd0;
      end else if (contended_s && (streak_r < MAX_HOLD_C)) begin
        streak_nxt_s = streak_r + 8'd1;
      end else begin
        streak_nxt_s = streak_r;
      end
    end else begin
      last_owner_nxt_s = last_owner_r;
    end
  end

  // Arbitration state register; r1 is the nominal last owner so r0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_r <= 1'b1;
      streak_r     <= 8'd0;
    end else begin
      last_owner_r <= last_owner_nxt_s;
      streak_r     <= streak_nxt_s;
    end
  end

  // RAM-side registers; address and data hold while idle, only the write enable drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr <= {ADDR_W{1'b0}};
      ram_din  <= {DATA_W{1'b0}};
      ram_we   <= 1'b0;
    end else if (any_s) begin
      ram_addr <= grant1_s ? r1_addr  : r0_addr;
      ram_din  <= grant1_s ? r1_wdata : r0_wdata;
      ram_we   <= grant1_s ? r1_we    : r0_we;
    end else begin
      ram_we   <= 1'b0;
    end
  end

  // Response tag pipeline: stage 1 tracks the RAM access, the response strobes are stage 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r     <= 1'b0;
      s1_tag_r       <= 1'b0;
      r0_rsp_valid_r <= 1'b0;
      r1_rsp_valid_r <= 1'b0;
    end else begin
      s1_valid_r     <= any_s;
      s1_tag_r       <= grant1_s;
      r0_rsp_valid_r <= s1_valid_r & ~s1_tag_r;
      r1_rsp_valid_r <= s1_valid_r & s1_tag_r;
    end
  end

  assign r0_rsp_valid = r0_rsp_valid_r;
  assign r1_rsp_valid = r1_rsp_valid_r;
  // Read data is shared; each port qualifies it with its own strobe.
  assign r0_rsp_data  = ram_dout;
  assign r1_rsp_data  = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a read-first RAM model, a grant/response
// vector table and hand-written sequences for hazards, reset and idle hold.
module tb_ram_port_arbiter;

  localparam int DW = 64;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          preload;
  logic          r0_valid, r0_we, r0_lock, r1_valid, r1_we, r1_lock;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid;
  logic [DW-1:0] r0_rsp_data, r1_rsp_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_we;

  // Second instance with MAX_HOLD=1: shares the inputs, only its readies are checked.
  logic          h_r0_ready, h_r1_ready, h_r0_rsp_valid, h_r1_rsp_valid, h_ram_we;
  logic [DW-1:0] h_r0_rsp_data, h_r1_rsp_data, h_ram_din;
  logic [AW-1:0] h_ram_addr;
  logic [DW-1:0] h_ram_dout;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_lock(r0_lock),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_data(r0_rsp_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_lock(r1_lock),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_data(r1_rsp_data),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_HOLD(1)) dut_h1 (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(h_r0_ready), .r0_we(r0_we), .r0_lock(r0_lock),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rsp_valid(h_r0_rsp_valid), .r0_rsp_data(h_r0_rsp_data),
    .r1_valid(r1_valid), .r1_ready(h_r1_ready), .r1_we(r1_we), .r1_lock(r1_lock),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rsp_valid(h_r1_rsp_valid), .r1_rsp_data(h_r1_rsp_data),
    .ram_addr(h_ram_addr), .ram_din(h_ram_din), .ram_we(h_ram_we), .ram_dout(h_ram_dout)
  );

  assign h_ram_dout = {DW{1'b0}};

  // Single-clock read-first block RAM with registered output.
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < (1<<AW); a++) mem[a] <= {DW{1'b0}};
      mem[5] <= 64'h0000_0000_0000_00A5;
      mem[7] <= 64'h0000_0000_0000_0055;
      ram_dout <= {DW{1'b0}};
    end else begin
      ram_dout <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_din;
    end
  end

  typedef struct packed {
    logic v0, v1, l0, l1;
    logic e0, e1;   // expected readies, MAX_HOLD=4
    logic f0, f1;   // expected readies, MAX_HOLD=1
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    r0_valid = 1'b0; r1_valid = 1'b0; r0_we = 1'b0; r1_we = 1'b0;
    r0_lock = 1'b0; r1_lock = 1'b0;
    r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic er0, er1;
    // Contention without lock: strict alternation starting with r0.
    for (int i = 0; i < 6; i++)
      tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b0, (i % 2 == 0), (i % 2 == 1), (i % 2 == 0), (i % 2 == 1)};
    for (int i = 6; i < 8; i++) tbl[i] = '0;
    // r0 locked: four grants then one to r1 (MAX_HOLD=4); strict alternation for MAX_HOLD=1.
    for (int i = 8; i < 18; i++) begin
      automatic int k = i - 8;
      automatic logic g1 = (k == 4) || (k == 9);
      tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b0, ~g1, g1, (k % 2 == 0), (k % 2 == 1)};
    end
    for (int i = 18; i < 20; i++) tbl[i] = '0;

    idle_inputs();
    reset = 1'b1;
    preload = 1'b1;
    @(negedge clk);
    step();
    preload = 1'b0;
    step();
    reset = 1'b0;

    chk("reset_ram_we", {63'd0, ram_we}, 64'd0);
    chk("reset_ram_addr", {55'd0, ram_addr}, 64'd0);
    chk("reset_ram_din", ram_din, 64'd0);
    chk("reset_rsp_valid", {62'd0, r0_rsp_valid, r1_rsp_valid}, 64'd0);

    // Single r0 read of addr 5.
    r0_valid = 1'b1; r0_addr = 9'd5;
    #1 chk("single_ready", {62'd0, r0_ready, r1_ready}, 64'd2);
    step();
    idle_inputs();
    chk("single_ram_addr", {55'd0, ram_addr}, 64'd5);
    chk("single_rsp_t1", {62'd0, r0_rsp_valid, r1_rsp_valid}, 64'd0);
    step();
    chk("single_rsp_t2", {62'd0, r0_rsp_valid, r1_rsp_valid}, 64'd2);
    chk("single_rsp_data", r0_rsp_data, 64'hA5);
    step();
    chk("single_rsp_t3", {62'd0, r0_rsp_valid, r1_rsp_valid}, 64'd0);

    // Grant table: contention, then lock bound, with responses two cycles after each grant.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      r0_valid = tbl[i].v0; r1_valid = tbl[i].v1;
      r0_lock  = tbl[i].l0; r1_lock  = tbl[i].l1;
      er0 = (i >= 2) ? tbl[i-2].e0 : 1'b0;
      er1 = (i >= 2) ? tbl[i-2].e1 : 1'b0;
      #1;
      chk($sformatf("tbl%0d_ready", i), {62'd0, r0_ready, r1_ready}, {62'd0, tbl[i].e0, tbl[i].e1});
      chk($sformatf("tbl%0d_ready_h1", i), {62'd0, h_r0_ready, h_r1_ready}, {62'd0, tbl[i].f0, tbl[i].f1});
      chk($sformatf("tbl%0d_rsp", i), {62'd0, r0_rsp_valid, r1_rsp_valid}, {62'd0, er0, er1});
      step();
    end
    idle_inputs();

    // Write at T by r1, read of the same address at T+1 by r0.
    r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 9'd7; r1_wdata = 64'h1234;
    #1 chk("wr_ready", {62'd0, r0_ready, r1_ready}, 64'd1);
    step();
    idle_inputs();
    r0_valid = 1'b1; r0_addr = 9'd7;
    #1 chk("rd_ready", {62'd0, r0_ready, r1_ready}, 64'd2);
    chk("wr_ram_regs", {ram_we, ram_addr, ram_din[15:0]}, {1'b1, 9'd7, 16'h1234});
    step();
    idle_inputs();
    chk("wr_ack_valid", {62'd0, r0_rsp_valid, r1_rsp_valid}, 64'd1);
    chk("wr_ack_old_data", r1_rsp_data, 64'h55);
    chk("rd_ram_we", {63'd0, ram_we}, 64'd0);
    step();
    chk("rd_rsp_valid", {62'd0, r0_rsp_valid, r1_rsp_valid}, 64'd2);
    chk("rd_new_data", r0_rsp_data, 64'h1234);

    // Idle hold after a write.
    step();
    r0_valid = 1'b1; r0_we = 1'b1; r0_addr = 9'd9; r0_wdata = 64'hBEEF;
    step();
    idle_inputs();
    chk("hold_t1", {ram_we, ram_addr, ram_din[15:0]}, {1'b1, 9'd9, 16'hBEEF});
    step();
    chk("hold_t2", {ram_we, ram_addr, ram_din[15:0]}, {1'b0, 9'd9, 16'hBEEF});
    chk("hold_ack", {r0_rsp_valid, r0_rsp_data[15:0]}, {1'b1, 16'h0});
    step();

    // Reset mid-flight: accepts at T and T+1, reset sampled at the end of T+1.
    r0_valid = 1'b1; r0_addr = 9'd5;
    step();
    idle_inputs();
    r1_valid = 1'b1; r1_addr = 9'd7;
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    chk("rst_mid_t2", {61'd0, r0_rsp_valid, r1_rsp_valid, ram_we}, 64'd0);
    step();
    chk("rst_mid_t3", {62'd0, r0_rsp_valid, r1_rsp_valid}, 64'd0);
    r0_valid = 1'b1; r1_valid = 1'b1; r0_addr = 9'd7; r1_addr = 9'd5;
    #1 chk("rst_first_tie", {62'd0, r0_ready, r1_ready}, 64'd2);
    step();
    idle_inputs();
    step();
    chk("rst_ram_kept", {r0_rsp_valid, r0_rsp_data[15:0]}, {1'b1, 16'h1234});
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
